// File: rtl/puf_soc_pkg.sv
// Shared definitions for the PUF ring-oscillator count source:
// default widths/depths and the measurement FSM state encoding.
package puf_soc_pkg;

   localparam int unsigned CNT_BIT_SIZE_DEF = 32;
   localparam int unsigned SYNC_STAGES_DEF  = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COUNT   = 3'd1,
      ST_PUBLISH = 3'd2,
      ST_ACK_LO  = 3'd3,
      ST_ACK_HI  = 3'd4
   } ro_state_e;

endpackage

// File: rtl/puf_bit_sync.sv
// Single-bit multi-flop synchronizer with async active-low reset to 0.
//   clk    : destination clock
//   rst_n  : async active-low reset
//   i_d    : asynchronous input level
//   o_q    : synchronized level, SYNC_STAGES clk edges of delay
// SYNC_STAGES must be at least 2.
module puf_bit_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // Shift chain: stage 0 captures the raw input.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/puf_ro_cnt_src.sv
// Ring-oscillator count source: counts ro_clk edges inside a gate window
// supplied by the sys domain, publishes the count with a one-cycle valid
// pulse and then runs a level handshake on the sys-domain ready line.
//   ro_clk         : ring-oscillator clock (sole clock)
//   rst_n          : async active-low reset
//   i_gate         : measurement window, async to ro_clk
//   i_sys_ready    : destination ready level, async
//   i_clr_ovr      : overrun clear level, async
//   o_ro_cnt_valid : one-cycle pulse when a new count is published
//   o_ro_cnt       : published count, held between publications
//   o_ro_cnt_full  : published count saturated
//   o_busy         : FSM not idle
//   o_overrun      : sticky, a window start was dropped
module puf_ro_cnt_src
   import puf_soc_pkg::*;
#(
   parameter int unsigned CNT_BIT_SIZE = CNT_BIT_SIZE_DEF,
   parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF
) (
   input  logic                    ro_clk,
   input  logic                    rst_n,
   input  logic                    i_gate,
   input  logic                    i_sys_ready,
   input  logic                    i_clr_ovr,
   output logic                    o_ro_cnt_valid,
   output logic [CNT_BIT_SIZE-1:0] o_ro_cnt,
   output logic                    o_ro_cnt_full,
   output logic                    o_busy,
   output logic                    o_overrun
);

   logic gate_s;
   logic rdy_s;
   logic clr_s;

   ro_state_e               state_q,       state_d;
   logic [CNT_BIT_SIZE-1:0] cnt_q,         cnt_d;
   logic                    full_q,        full_d;
   logic [CNT_BIT_SIZE-1:0] ro_cnt_q,      ro_cnt_d;
   logic                    ro_cnt_full_q, ro_cnt_full_d;
   logic                    valid_q,       valid_d;
   logic                    busy_q,        busy_d;
   logic                    overrun_q,     overrun_d;
   logic                    gate_dly_q,    gate_dly_d;
   logic                    gate_rise_c;

   // Input synchronizers, one per asynchronous input.
   puf_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_gate (
      .clk   (ro_clk),
      .rst_n (rst_n),
      .i_d   (i_gate),
      .o_q   (gate_s)
   );

   puf_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rdy (
      .clk   (ro_clk),
      .rst_n (rst_n),
      .i_d   (i_sys_ready),
      .o_q   (rdy_s)
   );

   puf_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
      .clk   (ro_clk),
      .rst_n (rst_n),
      .i_d   (i_clr_ovr),
      .o_q   (clr_s)
   );

   assign gate_rise_c = gate_s & ~gate_dly_q;

   // Next-state and output logic. The published registers load while in
   // PUBLISH, so valid/count appear on the cycle after that state.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      full_d        = full_q;
      ro_cnt_d      = ro_cnt_q;
      ro_cnt_full_d = ro_cnt_full_q;
      valid_d       = 1'b0;
      gate_dly_d    = gate_s;

      unique case (state_q)
         ST_IDLE: begin
            // The rise cycle itself is the first counted edge.
            if (gate_rise_c) begin
               state_d = ST_COUNT;
               cnt_d   = CNT_BIT_SIZE'(1);
               full_d  = 1'b0;
            end
         end
         ST_COUNT: begin
            if (gate_s) begin
               if (&cnt_q) begin
                  full_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_BIT_SIZE'(1);
               end
            end else begin
               state_d = ST_PUBLISH;
            end
         end
         ST_PUBLISH: begin
            ro_cnt_d      = cnt_q;
            ro_cnt_full_d = full_q;
            valid_d       = 1'b1;
            state_d       = ST_ACK_LO;
         end
         ST_ACK_LO: begin
            if (!rdy_s) begin
               state_d = ST_ACK_HI;
            end
         end
         ST_ACK_HI: begin
            if (rdy_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d    = (state_d != ST_IDLE);
      // Set has priority over clear.
      overrun_d = (gate_rise_c && (state_q != ST_IDLE)) | (overrun_q & ~clr_s);
   end

   always_ff @(posedge ro_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         full_q        <= 1'b0;
         ro_cnt_q      <= '0;
         ro_cnt_full_q <= 1'b0;
         valid_q       <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         gate_dly_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         full_q        <= full_d;
         ro_cnt_q      <= ro_cnt_d;
         ro_cnt_full_q <= ro_cnt_full_d;
         valid_q       <= valid_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
         gate_dly_q    <= gate_dly_d;
      end
   end

   assign o_ro_cnt_valid = valid_q;
   assign o_ro_cnt       = ro_cnt_q;
   assign o_ro_cnt_full  = ro_cnt_full_q;
   assign o_busy         = busy_q;
   assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_puf_ro_cnt_src.sv
// Directed bench for puf_ro_cnt_src: a 32-bit and a 4-bit instance share
// the same stimulus; expected values are hand-computed per scenario.
module tb_puf_ro_cnt_src;
   import puf_soc_pkg::*;

   localparam int unsigned S = SYNC_STAGES_DEF;

   logic        ro_clk = 1'b0;
   logic        rst_n;
   logic        i_gate;
   logic        i_sys_ready;
   logic        i_clr_ovr;

   logic        o_ro_cnt_valid;
   logic [31:0] o_ro_cnt;
   logic        o_ro_cnt_full;
   logic        o_busy;
   logic        o_overrun;

   logic        n4_valid;
   logic [3:0]  n4_cnt;
   logic        n4_full;
   logic        n4_busy;
   logic        n4_overrun;

   int n_chk   = 0;
   int n_pass  = 0;
   int n_valid = 0;

   always #5 ro_clk = ~ro_clk;

   puf_ro_cnt_src dut (
      .ro_clk         (ro_clk),
      .rst_n          (rst_n),
      .i_gate         (i_gate),
      .i_sys_ready    (i_sys_ready),
      .i_clr_ovr      (i_clr_ovr),
      .o_ro_cnt_valid (o_ro_cnt_valid),
      .o_ro_cnt       (o_ro_cnt),
      .o_ro_cnt_full  (o_ro_cnt_full),
      .o_busy         (o_busy),
      .o_overrun      (o_overrun)
   );

   puf_ro_cnt_src #(.CNT_BIT_SIZE(4)) dut4 (
      .ro_clk         (ro_clk),
      .rst_n          (rst_n),
      .i_gate         (i_gate),
      .i_sys_ready    (i_sys_ready),
      .i_clr_ovr      (i_clr_ovr),
      .o_ro_cnt_valid (n4_valid),
      .o_ro_cnt       (n4_cnt),
      .o_ro_cnt_full  (n4_full),
      .o_busy         (n4_busy),
      .o_overrun      (n4_overrun)
   );

   // Count valid pulses of the 32-bit instance.
   always @(negedge ro_clk) begin
      if (o_ro_cnt_valid) n_valid <= n_valid + 1;
   end

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Gate high for exactly n sampling edges.
   task automatic gate_window(input int n);
      @(posedge ro_clk); #1 i_gate = 1'b1;
      repeat (n) @(posedge ro_clk);
      #1 i_gate = 1'b0;
   endtask

   // Edges after the first low-sampling edge until valid is seen; -1 on timeout.
   task automatic wait_valid(output int lat);
      bit done;
      lat  = -1;
      done = 1'b0;
      for (int i = 1; i <= 300 && !done; i++) begin
         @(posedge ro_clk); @(negedge ro_clk);
         if (o_ro_cnt_valid) begin
            lat  = i - 1;
            done = 1'b1;
         end
      end
   endtask

   // Ready 1->0->1 and wait for the FSM to go idle.
   task automatic handshake(input string tag);
      bit done;
      @(posedge ro_clk); #1 i_sys_ready = 1'b0;
      repeat (S + 2) @(posedge ro_clk);
      #1 i_sys_ready = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge ro_clk);
         if (!o_busy) done = 1'b1;
      end
      check_eq(tag, longint'(o_busy), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int v0;

      rst_n       = 1'b0;
      i_gate      = 1'b0;
      i_sys_ready = 1'b1;
      i_clr_ovr   = 1'b0;
      #1;
      check_eq("rst_valid",   longint'(o_ro_cnt_valid), 0);
      check_eq("rst_cnt",     longint'(o_ro_cnt), 0);
      check_eq("rst_full",    longint'(o_ro_cnt_full), 0);
      check_eq("rst_busy",    longint'(o_busy), 0);
      check_eq("rst_overrun", longint'(o_overrun), 0);
      repeat (3) @(posedge ro_clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge ro_clk);

      // 100-edge window, ready held high then toggled.
      v0 = n_valid;
      gate_window(100);
      wait_valid(lat);
      check_eq("w100_latency", lat, S + 1);
      check_eq("w100_cnt",     longint'(o_ro_cnt), 100);
      check_eq("w100_full",    longint'(o_ro_cnt_full), 0);
      check_eq("w100_busy",    longint'(o_busy), 1);
      check_eq("w100_cnt4",    longint'(n4_cnt), 15);
      check_eq("w100_full4",   longint'(n4_full), 1);
      @(negedge ro_clk);
      check_eq("w100_valid_width", longint'(o_ro_cnt_valid), 0);
      handshake("w100_idle");
      check_eq("w100_cnt_hold", longint'(o_ro_cnt), 100);
      check_eq("w100_pulses",   n_valid - v0, 1);

      // 20-edge window: 4-bit instance saturates.
      gate_window(20);
      wait_valid(lat);
      check_eq("w20_cnt4",  longint'(n4_cnt), 15);
      check_eq("w20_full4", longint'(n4_full), 1);
      check_eq("w20_cnt",   longint'(o_ro_cnt), 20);
      check_eq("w20_full",  longint'(o_ro_cnt_full), 0);
      handshake("w20_idle");

      // Single-edge window.
      gate_window(1);
      wait_valid(lat);
      check_eq("w1_latency", lat, S + 1);
      check_eq("w1_cnt",     longint'(o_ro_cnt), 1);
      check_eq("w1_cnt4",    longint'(n4_cnt), 1);
      check_eq("w1_full4",   longint'(n4_full), 0);
      handshake("w1_idle");

      // Overrun: second window while waiting in ACK_LO.
      v0 = n_valid;
      gate_window(5);
      wait_valid(lat);
      check_eq("ovr_first_cnt", longint'(o_ro_cnt), 5);
      gate_window(3);
      repeat (6) @(negedge ro_clk);
      check_eq("ovr_set",      longint'(o_overrun), 1);
      check_eq("ovr_set4",     longint'(n4_overrun), 1);
      check_eq("ovr_busy",     longint'(o_busy), 1);
      check_eq("ovr_pulses",   n_valid - v0, 1);
      check_eq("ovr_cnt_hold", longint'(o_ro_cnt), 5);
      @(posedge ro_clk); #1 i_clr_ovr = 1'b1;
      repeat (S) @(posedge ro_clk);
      @(negedge ro_clk);
      check_eq("ovr_clr_early", longint'(o_overrun), 1);
      @(posedge ro_clk); @(negedge ro_clk);
      check_eq("ovr_clr", longint'(o_overrun), 0);
      // Set while clear is held: set wins for that cycle.
      @(posedge ro_clk); #1 i_gate = 1'b1;
      repeat (S + 1) @(posedge ro_clk);
      @(negedge ro_clk);
      check_eq("ovr_set_wins", longint'(o_overrun), 1);
      @(posedge ro_clk); @(negedge ro_clk);
      check_eq("ovr_clr_after", longint'(o_overrun), 0);
      @(posedge ro_clk); #1 i_gate = 1'b0; i_clr_ovr = 1'b0;
      handshake("ovr_idle");

      // Ready never drops: FSM parks in ACK_LO.
      v0 = n_valid;
      gate_window(7);
      wait_valid(lat);
      repeat (30) @(negedge ro_clk);
      check_eq("park_busy",   longint'(o_busy), 1);
      check_eq("park_cnt",    longint'(o_ro_cnt), 7);
      check_eq("park_pulses", n_valid - v0, 1);
      handshake("park_idle");

      // Reset mid-count, then a fresh 10-edge window.
      @(posedge ro_clk); #1 i_gate = 1'b1;
      repeat (37 + S) @(posedge ro_clk);
      #3 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", longint'(o_ro_cnt_valid), 0);
      check_eq("mid_rst_cnt",   longint'(o_ro_cnt), 0);
      check_eq("mid_rst_full",  longint'(o_ro_cnt_full), 0);
      check_eq("mid_rst_busy",  longint'(o_busy), 0);
      check_eq("mid_rst_cnt4",  longint'(n4_cnt), 0);
      i_gate = 1'b0;
      repeat (2) @(posedge ro_clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge ro_clk);
      v0 = n_valid;
      gate_window(10);
      wait_valid(lat);
      check_eq("w10_latency", lat, S + 1);
      check_eq("w10_cnt",     longint'(o_ro_cnt), 10);
      check_eq("w10_cnt4",    longint'(n4_cnt), 10);
      check_eq("w10_full",    longint'(o_ro_cnt_full), 0);
      handshake("w10_idle");
      check_eq("w10_pulses", n_valid - v0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
